// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared types and constants for the ROM arbiter
package rom_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, READ, RESP} arb_state_t;

    localparam int RESP_LATENCY = 2;

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from last+1 with wrap at NREQ-1
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] last,
    output logic [SELW-1:0] sel,
    output logic            any
);

    logic [SELW-1:0] idx;

    // walk offsets from farthest to nearest so the nearest requester after last wins
    always_comb begin
        sel = '0;
        idx = '0;
        any = |req;
        for (int k = NREQ; k >= 1; k--) begin
            idx = SELW'((int'(last) + k) % NREQ);
            if (req[idx]) sel = idx;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one asynchronous ROM with registered address, data and ack
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDRW = $clog2(DEPTH),
    parameter int SELW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  busy,
    output logic [ADDRW-1:0]      rom_addr,
    input  logic [WIDTH-1:0]      rom_data
);

    arb_state_t       state_q, state_d;
    logic [SELW-1:0]  last_q, last_d;
    logic [SELW-1:0]  grant_q, grant_d;
    logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [SELW-1:0]  sel;
    logic             any;

    rr_pick #(.NREQ(NREQ), .SELW(SELW)) u_pick (
        .req  (req),
        .last (last_q),
        .sel  (sel),
        .any  (any)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        rom_addr_d = rom_addr_q;
        rd_data_d  = rd_data_q;
        ack_d      = '0;
        case (state_q)
            IDLE: if (any) begin
                rom_addr_d = req_addr[int'(sel)*ADDRW +: ADDRW];
                grant_d    = sel;
                state_d    = READ;
            end
            READ: begin
                rd_data_d = rom_data;
                ack_d     = NREQ'(1) << grant_q;
                last_d    = grant_q;
                state_d   = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= SELW'(NREQ - 1);
            grant_q    <= '0;
            rom_addr_q <= '0;
            rd_data_q  <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            rom_addr_q <= rom_addr_d;
            rd_data_q  <= rd_data_d;
            ack_q      <= ack_d;
        end
    end

    assign ack      = ack_q;
    assign rd_data  = rd_data_q;
    assign rom_addr = rom_addr_q;
    assign busy     = state_q != IDLE;

endmodule
